router_pkt_reader: RTL

Destination-side consumer for one router output FIFO. It pulls a complete packet (header, payload, parity) from the FIFO read port, streams the payload to the output client, and checks parity. It then issues a flush read so the FIFO rewinds its pointers. A stall watchdog aborts the packet and soft-resets the FIFO if the client stops accepting bytes.

---
 rtl/router_pkt_reader.sv | 138 +++++++++++++
 1 files changed

// File: rtl/router_pkt_reader.sv
// Destination-side packet reader for one router output FIFO: pulls header,
// payload and parity, streams payload to the client, checks parity, flushes.
module router_pkt_reader #(
  parameter int LEN_W       = 6,
  parameter int STALL_LIMIT = 30
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             soft_reset,
  input  logic             empty,
  input  logic             pkt_valid,
  input  logic [7:0]       data_in,
  input  logic             ready_in,
  output logic             read_enb,
  output logic             fifo_soft_reset,
  output logic [7:0]       byte_out,
  output logic             byte_valid,
  output logic [1:0]       pkt_addr,
  output logic [LEN_W-1:0] pkt_len,
  output logic             pkt_done,
  output logic             parity_err,
  output logic             pkt_abort
);

  localparam int SW = $clog2(STALL_LIMIT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_HDR, S_WAIT_HDR, S_RD_BODY, S_RD_FLUSH, S_DONE
  } state_t;

  typedef enum logic [1:0] {T_NONE, T_HDR, T_PAY, T_PAR} tag_t;

  state_t           r_state;
  tag_t             r_tag;
  logic [LEN_W:0]   r_rem;
  logic [7:0]       r_par_acc;
  logic [7:0]       r_par;
  logic [SW-1:0]    r_stall;
  logic             r_done;
  logic             r_abort;
  logic [1:0]       r_addr;
  logic [LEN_W-1:0] r_len;
  logic             w_pay;

  always_comb begin
    read_enb = 1'b0;
    case (r_state)
      S_RD_HDR:   read_enb = 1'b1;
      S_RD_BODY:  read_enb = ready_in;
      S_RD_FLUSH: read_enb = 1'b1;
      default:    read_enb = 1'b0;
    endcase
  end

  // FIFO output is registered, so a payload byte is forwarded straight from
  // data_in in the cycle after its read, qualified by the read tag.
  assign w_pay           = (r_tag == T_PAY);
  assign byte_valid      = w_pay;
  assign byte_out        = w_pay ? data_in : 8'h00;
  assign pkt_addr        = r_addr;
  assign pkt_len         = r_len;
  assign pkt_done        = r_done;
  assign parity_err      = r_done && (r_par_acc != r_par);
  assign pkt_abort       = r_abort;
  assign fifo_soft_reset = r_abort;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_tag     <= T_NONE;
      r_rem     <= '0;
      r_par_acc <= '0;
      r_par     <= '0;
      r_stall   <= '0;
      r_done    <= 1'b0;
      r_abort   <= 1'b0;
      r_addr    <= '0;
      r_len     <= '0;
    end else if (soft_reset) begin
      r_state   <= S_IDLE;
      r_tag     <= T_NONE;
      r_rem     <= '0;
      r_par_acc <= '0;
      r_par     <= '0;
      r_stall   <= '0;
      r_done    <= 1'b0;
      r_abort   <= 1'b0;
      r_addr    <= '0;
      r_len     <= '0;
    end else begin
      r_done  <= 1'b0;
      r_abort <= 1'b0;
      r_tag   <= T_NONE;
      if (w_pay) r_par_acc <= r_par_acc ^ data_in;
      case (r_state)
        S_IDLE: begin
          if (!empty && !pkt_valid && ready_in) r_state <= S_RD_HDR;
        end
        S_RD_HDR: begin
          r_tag   <= T_HDR;
          r_state <= S_WAIT_HDR;
        end
        S_WAIT_HDR: begin
          r_len     <= data_in[7:2];
          r_addr    <= data_in[1:0];
          r_par_acc <= data_in;
          // rem counts payload plus the trailing parity byte
          r_rem     <= {1'b0, data_in[7:2]} + 7'd1;
          r_stall   <= '0;
          r_state   <= S_RD_BODY;
        end
        S_RD_BODY: begin
          if (ready_in) begin
            r_stall <= '0;
            r_rem   <= r_rem - 7'd1;
            r_tag   <= (r_rem == 7'd1) ? T_PAR : T_PAY;
            if (r_rem == 7'd1) r_state <= S_RD_FLUSH;
          end else if (r_stall == SW'(STALL_LIMIT - 1)) begin
            r_abort <= 1'b1;
            r_stall <= '0;
            r_rem   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_stall <= r_stall + SW'(1);
          end
        end
        S_RD_FLUSH: begin
          r_par   <= data_in;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
